// File: rtl/vga_pixel_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_stream_if
// Description : Upstream pixel handshake (data, start-of-frame, valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_stream_if #(
  parameter int DW = 12
);
  logic [DW-1:0] s_data;
  logic          s_sof;
  logic          s_valid;
  logic          s_ready;

  modport master (output s_data, s_sof, s_valid, input s_ready);
  modport slave  (input s_data, s_sof, s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/vga_pixel_stream.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_stream
// Description : Pixel FIFO that locks an upstream frame stream onto the VGA
//               timing core and drives registered RGB444 colour and syncs.
//               Optional macro VGA_UNDERFLOW_COUNT_EN adds underflow_count.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_stream #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int HW    = 10,
  parameter int VW    = 10
) (
  input  wire logic          pixClk,
  input  wire logic          rst,
  vga_pixel_stream_if.slave  s,
  input  wire logic [HW-1:0] horiz_counter,
  input  wire logic [VW-1:0] vert_counter,
  input  wire logic          video,
  input  wire logic          hsync_in,
  input  wire logic          vsync_in,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               underflow,
  output logic               locked
`ifdef VGA_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]        underflow_count
`endif
);

  localparam int            c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW:0]     fifo_mem [DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]   count_q, count_d;
  logic [DW-1:0]   colour_q, colour_d;
  logic            hs_q, vs_q;
  logic            underflow_q, underflow_d;
  logic            locked_q, locked_d;
  logic            aligned_q, aligned_d;

  logic          push, pop, empty, head_sof, frame_start;
  logic [DW-1:0] head_data;

  assign s.s_ready   = (count_q < c_full);
  assign push        = s.s_valid && s.s_ready;
  assign empty       = (count_q == '0);
  assign head_sof    = fifo_mem[rd_ptr_q][DW];
  assign head_data   = fifo_mem[rd_ptr_q][DW-1:0];
  assign frame_start = (horiz_counter == '0) && (vert_counter == '0);

  always_ff @(posedge pixClk) begin
    if (push) fifo_mem[wr_ptr_q] <= {s.s_sof, s.s_data};
  end

  // aligned_q marks that the head entry is the sof pixel ALIGN locked onto,
  // so its first pop in STREAM is legal even though frame_start has passed.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    colour_d    = '0;
    underflow_d = 1'b0;
    aligned_d   = aligned_q;
    case (state_q)
      HUNT: begin
        aligned_d = 1'b0;
        if (!empty) begin
          if (head_sof) state_d = ALIGN;
          else          pop     = 1'b1;
        end
      end
      ALIGN: begin
        if (frame_start) begin
          state_d   = STREAM;
          aligned_d = 1'b1;
        end
      end
      STREAM: begin
        if (video) begin
          if (empty) begin
            underflow_d = 1'b1;
            aligned_d   = 1'b0;
            state_d     = HUNT;
          end else if (head_sof && !frame_start && !aligned_q) begin
            // Early sof stays at the head so ALIGN can lock onto it.
            underflow_d = 1'b1;
            state_d     = ALIGN;
          end else begin
            pop       = 1'b1;
            colour_d  = head_data;
            aligned_d = 1'b0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    locked_d = (state_d == STREAM);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (c_aw + 1)'(1);
    else if (pop && !push) count_d = count_q - (c_aw + 1)'(1);
  end

  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      colour_q    <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      underflow_q <= 1'b0;
      locked_q    <= 1'b0;
      aligned_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      colour_q    <= colour_d;
      hs_q        <= hsync_in;
      vs_q        <= vsync_in;
      underflow_q <= underflow_d;
      locked_q    <= locked_d;
      aligned_q   <= aligned_d;
    end
  end

  assign vga_r     = colour_q[11:8];
  assign vga_g     = colour_q[7:4];
  assign vga_b     = colour_q[3:0];
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign underflow = underflow_q;
  assign locked    = locked_q;

`ifdef VGA_UNDERFLOW_COUNT_EN
  logic [15:0] uf_count_q, uf_count_d;

  always_comb begin
    uf_count_d = uf_count_q;
    if (underflow_d && (uf_count_q != 16'hFFFF)) uf_count_d = uf_count_q + 16'd1;
  end

  always_ff @(posedge pixClk or posedge rst) begin
    if (rst) uf_count_q <= '0;
    else     uf_count_q <= uf_count_d;
  end

  assign underflow_count = uf_count_q;
`endif

endmodule
`default_nettype wire
